// File: rtl/ifq_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC and issues one aligned line
// read per fetch. It pushes hit lines into the IFQ and applies redirects.
module ifq_fetch_ctrl #(
  parameter int                ADDR_W      = 32,
  parameter int                FETCH_BYTES = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              cache_req,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_hit,
  input  logic              cache_miss,
  input  logic              cache_refill_done,
  input  logic              q_full,
  output logic              q_push,
  output logic [ADDR_W-1:0] q_push_pc,
  output logic              stage_flush
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(FETCH_BYTES - 1);
  localparam logic [ADDR_W-1:0] LINE_INC  = ADDR_W'(FETCH_BYTES);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_MISS = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              resp_hit;

  // Both hit and miss high, or neither, is handled as a miss.
  assign resp_hit = cache_hit && !cache_miss;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
    end else if (redirect_valid) begin
      state <= S_REQ;
      pc    <= redirect_pc & ~LINE_MASK;
    end else begin
      case (state)
        S_REQ: begin
          if (!q_full) state <= S_RESP;
        end
        S_RESP: begin
          if (resp_hit) begin
            state <= S_REQ;
            pc    <= pc + LINE_INC;
          end else begin
            state <= S_MISS;
          end
        end
        S_MISS: begin
          // Refill-done only counts while waiting here; stale pulses fall away.
          if (cache_refill_done) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  always_comb begin
    cache_req   = 1'b0;
    q_push      = 1'b0;
    stage_flush = 1'b0;
    if (rst) begin
      stage_flush = redirect_valid;
      cache_req   = !redirect_valid && (state == S_REQ) && !q_full;
      // Room was guaranteed when the request issued (single producer).
      q_push      = !redirect_valid && (state == S_RESP) && resp_hit;
    end
  end

  assign cache_addr = pc;
  assign q_push_pc  = pc;

endmodule
